// File: rtl/scmem_pkg.sv
// Shared scmem types for the L2 <-> directory interface, plus the responder FSM state
// and a saturating counter helper.
package scmem;

    typedef logic [49:0]      SC_paddr_type;
    typedef logic [4:0]       SC_nodeid_type;
    typedef logic [4:0]       L2_reqid_type;
    typedef logic [5:0]       DR_reqid_type;
    typedef logic [2:0]       SC_snack_type;
    typedef logic [7:0]       SC_disp_mask_type;
    typedef logic [7:0][63:0] SC_line_type;

    localparam SC_snack_type DR_SNACK_DATA = 3'd1;

    typedef struct packed {
        SC_nodeid_type nid;
        L2_reqid_type  l2id;
        SC_paddr_type  paddr;
    } I_l2todr_req_type;

    typedef struct packed {
        SC_nodeid_type nid;
        L2_reqid_type  l2id;
        DR_reqid_type  drid;
        SC_snack_type  snack;
        SC_line_type   line;
        SC_paddr_type  paddr;
    } I_drtol2_snack_type;

    typedef struct packed {
        SC_nodeid_type    nid;
        L2_reqid_type     l2id;
        SC_disp_mask_type mask;
        SC_line_type      line;
        SC_paddr_type     paddr;
    } I_l2todr_disp_type;

    typedef struct packed {
        SC_nodeid_type nid;
        L2_reqid_type  l2id;
    } I_drtol2_dack_type;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SNACK,
        DACK
    } dr_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic en);
        return (en && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
    endfunction

endpackage

// File: rtl/dr_line_store.sv
// Backing store of cache lines: one combinational read port, one word-masked write port,
// cleared to zero by synchronous reset.
module dr_line_store
    import scmem::*;
#(
    parameter int unsigned NLINES = 16,
    localparam int unsigned IDXW = (NLINES > 1) ? $clog2(NLINES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDXW-1:0]  rd_idx,
    output SC_line_type      rd_line,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_idx,
    input  SC_disp_mask_type wr_mask,
    input  SC_line_type      wr_line
);

    SC_line_type lines [NLINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NLINES; i++) begin
                lines[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned w = 0; w < 8; w++) begin
                if (wr_mask[w]) begin
                    lines[wr_idx][w] <= wr_line[w];
                end
            end
        end
    end

    assign rd_line = lines[rd_idx];

endmodule

// File: rtl/dr_mem_responder.sv
// Directory-side memory responder: serves L2 line requests and displacements from a local
// line store one at a time, and counts activity on every inbound channel.
module dr_mem_responder
    import scmem::*;
#(
    parameter int unsigned   NLINES = 16,
    parameter SC_nodeid_type NODEID = '0
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               l2todr_req_valid,
    output logic               l2todr_req_retry,
    input  I_l2todr_req_type   l2todr_req,

    output logic               drtol2_snack_valid,
    input  logic               drtol2_snack_retry,
    output I_drtol2_snack_type drtol2_snack,

    input  logic               l2todr_disp_valid,
    output logic               l2todr_disp_retry,
    input  I_l2todr_disp_type  l2todr_disp,

    output logic               drtol2_dack_valid,
    input  logic               drtol2_dack_retry,
    output I_drtol2_dack_type  drtol2_dack,

    input  logic               l2todr_snoop_ack_valid,
    output logic               l2todr_snoop_ack_retry,
    input  L2_reqid_type       l2todr_snoop_ack,

    input  logic               l2todr_pfreq_valid,
    output logic               l2todr_pfreq_retry,
    input  SC_paddr_type       l2todr_pfreq,

    output logic [7:0]         nreqs,
    output logic [7:0]         ndisp,
    output logic [7:0]         nsnoop_acks,
    output logic [7:0]         npfreq
);

    localparam int unsigned IDXW = (NLINES > 1) ? $clog2(NLINES) : 1;

    dr_state_t          state;
    L2_reqid_type       req_l2id;
    logic [49:6]        req_line_addr;
    DR_reqid_type       drid;
    I_drtol2_snack_type snack_q;
    I_drtol2_dack_type  dack_q;
    SC_line_type        rd_line;
    logic               req_fire;
    logic               disp_fire;
    logic               unused_bits;

    // A pending disp blocks the req channel even in IDLE, which gives disp priority.
    always_comb begin
        l2todr_disp_retry = reset || (state != IDLE);
        l2todr_req_retry  = reset || (state != IDLE) || l2todr_disp_valid;
    end

    assign req_fire  = l2todr_req_valid && !l2todr_req_retry;
    assign disp_fire = l2todr_disp_valid && !l2todr_disp_retry;

    assign l2todr_snoop_ack_retry = 1'b0;
    assign l2todr_pfreq_retry     = 1'b0;

    assign drtol2_snack_valid = (state == SNACK) && !reset;
    assign drtol2_dack_valid  = (state == DACK) && !reset;
    assign drtol2_snack       = snack_q;
    assign drtol2_dack        = dack_q;

    dr_line_store #(
        .NLINES (NLINES)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (req_line_addr[6 +: IDXW]),
        .rd_line (rd_line),
        .wr_en   (disp_fire),
        .wr_idx  (l2todr_disp.paddr[6 +: IDXW]),
        .wr_mask (l2todr_disp.mask),
        .wr_line (l2todr_disp.line)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            req_l2id      <= '0;
            req_line_addr <= '0;
            drid          <= '0;
            snack_q       <= '0;
            dack_q        <= '0;
            nreqs         <= '0;
            ndisp         <= '0;
            nsnoop_acks   <= '0;
            npfreq        <= '0;
        end else begin
            nreqs       <= sat_inc(nreqs, req_fire);
            ndisp       <= sat_inc(ndisp, disp_fire);
            nsnoop_acks <= sat_inc(nsnoop_acks, l2todr_snoop_ack_valid);
            npfreq      <= sat_inc(npfreq, l2todr_pfreq_valid);

            case (state)
                IDLE: begin
                    if (disp_fire) begin
                        dack_q.nid  <= NODEID;
                        dack_q.l2id <= l2todr_disp.l2id;
                        state       <= DACK;
                    end else if (req_fire) begin
                        req_l2id      <= l2todr_req.l2id;
                        req_line_addr <= l2todr_req.paddr[49:6];
                        state         <= READ;
                    end
                end
                READ: begin
                    snack_q.nid   <= NODEID;
                    snack_q.l2id  <= req_l2id;
                    snack_q.drid  <= drid;
                    snack_q.snack <= DR_SNACK_DATA;
                    snack_q.line  <= rd_line;
                    snack_q.paddr <= {req_line_addr, 6'b0};
                    state         <= SNACK;
                end
                SNACK: begin
                    if (!drtol2_snack_retry) begin
                        drid  <= drid + 1'b1;
                        state <= IDLE;
                    end
                end
                DACK: begin
                    if (!drtol2_dack_retry) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Snoop acks, prefetch addresses and unused payload fields are consumed without effect.
    assign unused_bits = ^{l2todr_snoop_ack, l2todr_pfreq, l2todr_req, l2todr_disp.nid,
                           l2todr_disp.paddr};

endmodule

// File: tb/tb_dr_mem_responder.sv
// Scoreboard bench for dr_mem_responder: directed scenarios then randomized traffic checked
// against a behavioural line-store / counter model.
module tb_dr_mem_responder;
    import scmem::*;

    localparam int unsigned   NL  = 16;
    localparam SC_nodeid_type NID = 5'd3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic               req_valid = 1'b0;
    logic               req_retry;
    I_l2todr_req_type   req = '0;
    logic               snack_valid;
    logic               snack_retry = 1'b0;
    I_drtol2_snack_type snack;
    logic               disp_valid = 1'b0;
    logic               disp_retry;
    I_l2todr_disp_type  disp = '0;
    logic               dack_valid;
    logic               dack_retry = 1'b0;
    I_drtol2_dack_type  dack;
    logic               snoop_valid = 1'b0;
    logic               snoop_retry;
    L2_reqid_type       snoop = '0;
    logic               pf_valid = 1'b0;
    logic               pf_retry;
    SC_paddr_type       pf = '0;
    logic [7:0]         nreqs, ndisp, nsnoop_acks, npfreq;

    always #5 clk = ~clk;

    dr_mem_responder #(
        .NLINES (NL),
        .NODEID (NID)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .l2todr_req_valid       (req_valid),
        .l2todr_req_retry       (req_retry),
        .l2todr_req             (req),
        .drtol2_snack_valid     (snack_valid),
        .drtol2_snack_retry     (snack_retry),
        .drtol2_snack           (snack),
        .l2todr_disp_valid      (disp_valid),
        .l2todr_disp_retry      (disp_retry),
        .l2todr_disp            (disp),
        .drtol2_dack_valid      (dack_valid),
        .drtol2_dack_retry      (dack_retry),
        .drtol2_dack            (dack),
        .l2todr_snoop_ack_valid (snoop_valid),
        .l2todr_snoop_ack_retry (snoop_retry),
        .l2todr_snoop_ack       (snoop),
        .l2todr_pfreq_valid     (pf_valid),
        .l2todr_pfreq_retry     (pf_retry),
        .l2todr_pfreq           (pf),
        .nreqs                  (nreqs),
        .ndisp                  (ndisp),
        .nsnoop_acks            (nsnoop_acks),
        .npfreq                 (npfreq)
    );

    int checks   = 0;
    int failures = 0;

    SC_line_type        mem_m [NL];
    I_drtol2_snack_type exp_snack [$];
    I_drtol2_dack_type  exp_dack [$];
    int                 drid_m = 0;
    int                 c_req = 0, c_disp = 0, c_snoop = 0, c_pf = 0;
    int                 cycle = 0;
    int                 dack_done_cycle = -1;
    int                 req_acc_cycle = -1;
    logic               snack_held = 1'b0, dack_held = 1'b0;
    I_drtol2_snack_type snack_prev = '0;
    I_drtol2_dack_type  dack_prev = '0;
    logic               bp_rand = 1'b0, bp_force = 1'b0, bg_en = 1'b0, sat_mode = 1'b0;

    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=no-event", name);
    endtask

    function automatic int sat(input int c);
        return (c < 255) ? c + 1 : 255;
    endfunction

    function automatic int line_idx(input SC_paddr_type pa);
        return int'((pa >> 6) % NL);
    endfunction

    // Scoreboard and reference model: predicts at the negedge before each accepting edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_snack.delete();
            exp_dack.delete();
            foreach (mem_m[i]) mem_m[i] = '0;
            drid_m = 0;
            c_req = 0; c_disp = 0; c_snoop = 0; c_pf = 0;
            snack_held = 1'b0;
            dack_held  = 1'b0;
        end else begin
            if (snack_held) begin
                chk("snack_hold_valid", 640'(snack_valid), 640'(1'b1));
                chk("snack_hold_payload", 640'(snack), 640'(snack_prev));
            end
            if (dack_held) begin
                chk("dack_hold_valid", 640'(dack_valid), 640'(1'b1));
                chk("dack_hold_payload", 640'(dack), 640'(dack_prev));
            end
            snack_held = snack_valid && snack_retry;
            snack_prev = snack;
            dack_held  = dack_valid && dack_retry;
            dack_prev  = dack;

            if (snack_valid && !snack_retry) begin
                if (exp_snack.size() == 0) flag("unexpected_snack");
                else chk("snack_payload", 640'(snack), 640'(exp_snack.pop_front()));
            end
            if (dack_valid && !dack_retry) begin
                dack_done_cycle = cycle;
                if (exp_dack.size() == 0) flag("unexpected_dack");
                else chk("dack_payload", 640'(dack), 640'(exp_dack.pop_front()));
            end

            if (req_valid && disp_valid) chk("disp_priority_req_retry", 640'(req_retry), 640'(1'b1));

            if (disp_valid && !disp_retry) begin
                for (int w = 0; w < 8; w++)
                    if (disp.mask[w]) mem_m[line_idx(disp.paddr)][w] = disp.line[w];
                exp_dack.push_back('{nid: NID, l2id: disp.l2id});
                c_disp = sat(c_disp);
            end
            if (req_valid && !req_retry) begin
                exp_snack.push_back('{nid: NID, l2id: req.l2id, drid: DR_reqid_type'(drid_m),
                                      snack: DR_SNACK_DATA, line: mem_m[line_idx(req.paddr)],
                                      paddr: req.paddr & ~SC_paddr_type'(63)});
                drid_m = (drid_m + 1) % 64;
                c_req = sat(c_req);
                req_acc_cycle = cycle;
            end
            if (snoop_valid) c_snoop = sat(c_snoop);
            if (pf_valid) c_pf = sat(c_pf);
        end
    end

    // Response backpressure and side-channel traffic.
    always @(posedge clk) begin
        #1;
        snack_retry = bp_force ? 1'b1 : (bp_rand ? ($urandom % 3 == 0) : 1'b0);
        dack_retry  = bp_rand ? ($urandom % 3 == 0) : 1'b0;
        snoop_valid = sat_mode || (bg_en && ($urandom % 2 == 0));
        pf_valid    = sat_mode || (bg_en && ($urandom % 2 == 0));
        snoop       = L2_reqid_type'($urandom);
        pf          = SC_paddr_type'({$urandom, $urandom});
    end

    task automatic send_req(input L2_reqid_type id, input SC_paddr_type pa);
        bit ok = 0;
        req.nid   = 5'd1;
        req.l2id  = id;
        req.paddr = pa;
        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!req_retry) begin
                ok = 1;
                break;
            end
        end
        if (!ok) flag("req_accept_timeout");
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic send_disp(input L2_reqid_type id, input SC_paddr_type pa,
                             input SC_disp_mask_type m, input SC_line_type ln);
        bit ok = 0;
        disp.nid   = 5'd1;
        disp.l2id  = id;
        disp.paddr = pa;
        disp.mask  = m;
        disp.line  = ln;
        disp_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!disp_retry) begin
                ok = 1;
                break;
            end
        end
        if (!ok) flag("disp_accept_timeout");
        @(posedge clk);
        #1 disp_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (exp_snack.size() == 0 && exp_dack.size() == 0 && !snack_valid && !dack_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) flag("drain_timeout");
    endtask

    task automatic wait_snack();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (snack_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) flag("snack_valid_timeout");
    endtask

    task automatic check_counters();
        chk("nreqs", 640'(nreqs), 640'(c_req));
        chk("ndisp", 640'(ndisp), 640'(c_disp));
        chk("nsnoop_acks", 640'(nsnoop_acks), 640'(c_snoop));
        chk("npfreq", 640'(npfreq), 640'(c_pf));
    endtask

    function automatic SC_line_type rand_line();
        SC_line_type l;
        for (int w = 0; w < 8; w++) l[w] = {$urandom, $urandom};
        return l;
    endfunction

    initial begin
        SC_line_type ln;
        int          seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_retry", 640'(req_retry), 640'(1'b1));
        chk("reset_disp_retry", 640'(disp_retry), 640'(1'b1));
        chk("reset_snack_valid", 640'(snack_valid), 640'(1'b0));
        chk("reset_dack_valid", 640'(dack_valid), 640'(1'b0));
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_counters();

        // Single read after reset: snack two cycles after accept
        send_req(5'd5, 50'h1040);
        @(negedge clk);
        chk("snack_latency_n1", 640'(snack_valid), 640'(1'b0));
        @(negedge clk);
        chk("snack_latency_n2", 640'(snack_valid), 640'(1'b1));
        chk("first_snack_paddr", 640'(snack.paddr), 640'(50'h1040));
        chk("first_snack_drid", 640'(snack.drid), 640'(6'd0));
        chk("first_snack_line", 640'(snack.line), 640'(0));
        chk("first_snack_l2id", 640'(snack.l2id), 640'(5'd5));
        drain();

        // Masked write then read back
        ln = '1;
        ln[0] = 64'hDEAD;
        send_disp(5'd7, 50'h80, 8'h01, ln);
        @(negedge clk);
        chk("dack_latency_n1", 640'(dack_valid), 640'(1'b1));
        chk("dack_l2id", 640'(dack.l2id), 640'(5'd7));
        drain();
        send_req(5'd9, 50'h80);
        wait_snack();
        ln = '0;
        ln[0] = 64'hDEAD;
        chk("masked_line_readback", 640'(snack.line), 640'(ln));
        drain();

        // disp wins over a simultaneous req; req accepted in the IDLE cycle after the dack
        fork
            send_disp(5'd2, 50'h3C0, 8'hA5, rand_line());
            send_req(5'd4, 50'h3C0);
            begin
                @(negedge clk);
                chk("prio_disp_retry", 640'(disp_retry), 640'(1'b0));
                chk("prio_req_retry", 640'(req_retry), 640'(1'b1));
            end
        join
        drain();
        chk("req_after_dack_cycle", 640'(req_acc_cycle), 640'(dack_done_cycle + 1));

        // Snack backpressure for 5 cycles
        bp_force = 1'b1;
        send_req(5'd11, 50'h2C0);
        wait_snack();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req_retry", 640'(req_retry), 640'(1'b1));
        end
        bp_force = 1'b0;
        drain();
        send_req(5'd12, 50'h2C0);
        drain();
        check_counters();

        // Counter saturation on the always-ready channels
        sat_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("snoop_retry_zero", 640'(snoop_retry), 640'(1'b0));
            chk("pfreq_retry_zero", 640'(pf_retry), 640'(1'b0));
        end
        sat_mode = 1'b0;
        @(posedge clk);
        #2;
        chk("nsnoop_saturated", 640'(nsnoop_acks), 640'(8'd255));
        chk("npfreq_saturated", 640'(npfreq), 640'(8'd255));
        check_counters();

        // Reset while a snack is held
        bp_force = 1'b1;
        send_req(5'd13, 50'h140);
        wait_snack();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midreset_snack_valid", 640'(snack_valid), 640'(1'b0));
        @(posedge clk);
        #1 reset = 1'b0;
        bp_force = 1'b0;
        #1;
        chk("midreset_nreqs", 640'(nreqs), 640'(8'd0));
        chk("midreset_nsnoop", 640'(nsnoop_acks), 640'(8'd0));
        chk("midreset_npfreq", 640'(npfreq), 640'(8'd0));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (snack_valid) seen++;
        end
        chk("no_stale_snack", 640'(seen), 640'(0));

        // Randomized traffic with random backpressure and side-channel activity
        bp_rand = 1'b1;
        bg_en   = 1'b1;
        for (int n = 0; n < 100; n++) begin
            int unsigned r;
            SC_paddr_type pa;
            r  = $urandom % 5;
            pa = SC_paddr_type'({$urandom, $urandom});
            if (r < 2) begin
                send_req(L2_reqid_type'($urandom), pa);
            end else if (r < 4) begin
                send_disp(L2_reqid_type'($urandom), pa, SC_disp_mask_type'($urandom), rand_line());
            end else begin
                fork
                    send_req(L2_reqid_type'($urandom), pa);
                    send_disp(L2_reqid_type'($urandom), pa ^ 50'h40,
                              SC_disp_mask_type'($urandom), rand_line());
                join
            end
        end
        bp_rand = 1'b0;
        bg_en   = 1'b0;
        drain();
        check_counters();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dr_mem_responder.md
DR_MEM_RESPONDER -- requirements
Module: dr_mem_responder

Interface
REQ-001 SHALL have parameter NLINES, default 16, meaning lines in the backing store (power of 2, 2..64).
REQ-002 SHALL have parameter NODEID, default 0, meaning the nid value returned in every response.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, synchronous and active-high.
REQ-005 SHALL have ports l2todr_req_valid (in, 1), l2todr_req_retry (out, 1) and l2todr_req (in, I_l2todr_req_type), the L2 miss request.
REQ-006 SHALL have ports drtol2_snack_valid (out, 1), drtol2_snack_retry (in, 1) and drtol2_snack (out, I_drtol2_snack_type), the data response.
REQ-007 SHALL have ports l2todr_disp_valid (in, 1), l2todr_disp_retry (out, 1) and l2todr_disp (in, I_l2todr_disp_type), the displacement.
REQ-008 SHALL have ports drtol2_dack_valid (out, 1), drtol2_dack_retry (in, 1) and drtol2_dack (out, I_drtol2_dack_type), the displacement ack.
REQ-009 SHALL have ports l2todr_snoop_ack_valid (in, 1), l2todr_snoop_ack_retry (out, 1) and l2todr_snoop_ack (in, L2_reqid_type).
REQ-010 SHALL have ports l2todr_pfreq_valid (in, 1), l2todr_pfreq_retry (out, 1) and l2todr_pfreq (in, SC_paddr_type).
REQ-011 SHALL have ports nreqs, ndisp, nsnoop_acks and npfreq, each out, 8 bits, activity counters.

Function
REQ-012 SHALL complete a transfer on any channel in a cycle where valid=1 and retry=0; the sender holds payload stable while retry=1.
REQ-013 SHALL hold every output payload stable, and keep its valid asserted, while the matching retry=1.
REQ-014 SHALL use FSM states IDLE, READ, SNACK and DACK.
REQ-015 In IDLE, SHALL accept a pending disp in preference to a pending req, and SHALL assert retry on the channel not accepted.
REQ-016 SHALL assert l2todr_req_retry and l2todr_disp_retry in every state except IDLE.
REQ-017 After a req is accepted in IDLE at cycle N, SHALL enter READ at N+1, read line index paddr[6+log2(NLINES)-1:6], and assert drtol2_snack_valid from N+2 in SNACK.
REQ-018 The snack payload SHALL carry nid=NODEID, l2id=request l2id, drid=drid counter, snack=DR_SNACK_DATA, line=stored line, and paddr=request paddr with bits [5:0] cleared.
REQ-019 SHALL increment the drid counter (DR_reqid_type, wrapping) on each completed snack.
REQ-020 After a disp is accepted at cycle N, SHALL write 64-bit word i of the line only where mask[i]=1, and assert drtol2_dack_valid from N+1 in DACK with nid=NODEID and l2id=disp l2id.
REQ-021 The written data SHALL be visible to a req accepted at N+2 or later.
REQ-022 SHALL return from SNACK or DACK to IDLE in the cycle after the handshake completes; the next accept can occur in that IDLE cycle.
REQ-023 SHALL tie l2todr_snoop_ack_retry and l2todr_pfreq_retry to 0; SHALL consume and discard snoop acks and prefetches in any state.
REQ-024 SHALL increment each counter by 1 per completed transfer on its channel, saturating at 255.
REQ-025 Simultaneous snoop ack, pfreq and req/disp transfers SHALL each be counted independently in the same cycle.

Reset
REQ-026 While reset=1, SHALL drive all valid outputs 0, state IDLE, drid 0, all counters 0, all store lines 0, and req/disp retry 1.
REQ-027 Reset asserted in READ, SNACK or DACK SHALL drop the in-flight response without emitting it; the first transfer after reset SHALL be accepted no earlier than one cycle after reset deasserts.

Structure
REQ-028 I_l2todr_req_type, I_drtol2_snack_type, I_l2todr_disp_type, I_drtol2_dack_type, L2_reqid_type, DR_reqid_type, SC_paddr_type and SC_line_type SHALL come from the shared scmem package; DR_SNACK_DATA SHALL be added there.
REQ-029 The line store SHALL be one sub-module, dr_line_store (1 read port, 1 masked write port, synchronous reset clear); the FSM and counters SHALL stay in the top.

Verification
REQ-030 Test single read after reset: req l2id=5, paddr=0x1040 at N -> snack valid at N+2, line=0, l2id=5, drid=0, paddr=0x1040.
REQ-031 Test write then read: disp mask=0x01, line0=0xDEAD, paddr=0x80 -> dack l2id matches; then req paddr=0x80 -> snack line0=0xDEAD and words 1..7 = 0.
REQ-032 Test priority: req and disp valid in the same IDLE cycle -> disp accepted, req_retry=1; req accepted after the dack completes.
REQ-033 Test backpressure: drtol2_snack_retry=1 for 5 cycles -> snack payload stable and valid held; req_retry=1 throughout; drid increments only once.
REQ-034 Test saturation: 300 back-to-back pfreqs with 1 snoop ack per cycle -> npfreq=255, nsnoop_acks=255, retry on both always 0.
REQ-035 Test reset mid-SNACK: reset asserted for 1 cycle -> snack_valid=0, counters=0, and no stale snack emitted afterward.
